pcie_ext_cap_walker: RTL and testbench

Walks the PCIe extended capability linked list in config space, starting at offset 0x100, and locates up to NUM_TARGETS capability IDs in a single pass. For each target it reports whether the ID was found, plus its offset and version. It issues dword reads over a valid/ready request channel with a separate response channel. It detects bad pointers, looping chains and read errors. It sits between the config-space register file and enumeration and power-management logic that needs capability locations.

---
 rtl/pcie_ecap_pkg.sv | 35 +++
 rtl/pcie_ext_cap_walker_if.sv | 19 +
 rtl/pcie_ecap_target_slot.sv | 43 ++++
 rtl/pcie_ext_cap_walker.sv | 217 +++++++++++++++++++++
 tb/tb_pcie_ext_cap_walker.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_ecap_pkg.sv
// Shared types and constants for the PCIe extended capability walker.
package pcie_ecap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_RSP  = 3'd1,
        ERR_PTR  = 3'd2,
        ERR_LOOP = 3'd3,
        ERR_ONES = 3'd4
    } err_code_e;

    localparam logic [11:0] ECAP_BASE         = 12'h100;
    localparam logic [15:0] ECAP_ID_NULL      = 16'h0000;
    localparam logic [31:0] ECAP_HDR_ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [11:0] next;
        logic [3:0]  ver;
        logic [15:0] id;
    } ecap_hdr_t;

    // A next pointer must land in extended space and be dword aligned.
    function automatic logic ptr_is_bad(input logic [11:0] p);
        return (p < ECAP_BASE) || (p[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pcie_ext_cap_walker_if.sv
// Config-space dword read channel: valid/ready request, unflow-controlled response.
interface pcie_ext_cap_walker_if;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [9:0]  rd_req_addr;
    logic        rd_rsp_valid;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_err;

    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
    );

    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err
    );
endinterface

// File: rtl/pcie_ecap_target_slot.sv
// One search slot: latched target ID plus its hit flag, offset and version.
module pcie_ecap_target_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic [15:0] id_i,
    input  logic        match_i,
    input  logic [11:0] offset_i,
    input  logic [3:0]  ver_i,
    output logic [15:0] id_o,
    output logic        found_o,
    output logic [11:0] offset_o,
    output logic [3:0]  ver_o
);
    logic [15:0] id_q;
    logic        found_q;
    logic [11:0] offset_q;
    logic [3:0]  ver_q;

    // Latch the target at walk start; record the first matching header only.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q     <= 16'h0000;
            found_q  <= 1'b0;
            offset_q <= 12'h000;
            ver_q    <= 4'h0;
        end else if (clear_i) begin
            id_q     <= id_i;
            found_q  <= 1'b0;
            offset_q <= 12'h000;
            ver_q    <= 4'h0;
        end else if (match_i) begin
            found_q  <= 1'b1;
            offset_q <= offset_i;
            ver_q    <= ver_i;
        end
    end

    assign id_o     = id_q;
    assign found_o  = found_q;
    assign offset_o = offset_q;
    assign ver_o    = ver_q;
endmodule

// File: rtl/pcie_ext_cap_walker.sv
// PCIe extended capability list walker. Optional build macro:
// PCIE_ECAP_EARLY_EXIT_EN - stop as soon as every enabled target is found.
module pcie_ext_cap_walker
    import pcie_ecap_pkg::*;
#(
    parameter int          NUM_TARGETS  = 4,
    parameter int          MAX_HOPS     = 48,
    parameter logic [11:0] START_OFFSET = ECAP_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_TARGETS*16-1:0] target_id,
    output logic                      busy,
    output logic                      done,
    pcie_ext_cap_walker_if.master     rd,
    output logic [NUM_TARGETS-1:0]    found,
    output logic [NUM_TARGETS*12-1:0] found_offset,
    output logic [NUM_TARGETS*4-1:0]  found_version,
    output logic                      err,
    output logic [2:0]                err_code,
    output logic [5:0]                hop_count
);
    localparam logic [9:0] START_DW = START_OFFSET[11:2];

    state_e     state_q, state_d;
    logic [11:0] cur_off_q, cur_off_d;
    ecap_hdr_t  hdr_q, hdr_d;
    logic       rsp_err_q, rsp_err_d;
    logic [5:0] hop_q, hop_d, hop_inc_s;
    err_code_e  err_code_q, err_code_d, chk_code_s;
    logic       req_valid_q, req_valid_d;
    logic [9:0] addr_q, addr_d;
    logic       busy_q, done_q, err_q;
    logic       chk_end_s, chk_hop_s, clear_s, match_s;
    logic [15:0] slot_id_s [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] found_s, hit_s;

    assign hop_inc_s = hop_q + 6'd1;

    for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
        pcie_ecap_target_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (clear_s),
            .id_i     (target_id[16*g +: 16]),
            .match_i  (match_s && hit_s[g]),
            .offset_i (cur_off_q),
            .ver_i    (hdr_q.ver),
            .id_o     (slot_id_s[g]),
            .found_o  (found_s[g]),
            .offset_o (found_offset[12*g +: 12]),
            .ver_o    (found_version[4*g +: 4])
        );
    end

    // A slot hits when it is enabled, still searching and its ID equals the header ID.
    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            hit_s[i] = (slot_id_s[i] != ECAP_ID_NULL) && !found_s[i] && (slot_id_s[i] == hdr_q.id);
        end
    end

`ifdef PCIE_ECAP_EARLY_EXIT_EN
    logic all_found_s;

    // True when no enabled slot remains unfound after this header's hits.
    always_comb begin
        all_found_s = 1'b1;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if ((slot_id_s[i] != ECAP_ID_NULL) && !found_s[i] && !hit_s[i]) begin
                all_found_s = 1'b0;
            end else begin
                all_found_s = all_found_s;
            end
        end
    end
`endif

    // Evaluate the registered header in priority order: error, end or follow.
    always_comb begin
        chk_code_s = ERR_NONE;
        chk_end_s  = 1'b1;
        chk_hop_s  = 1'b0;
        if (rsp_err_q) begin
            chk_code_s = ERR_RSP;
        end else if (hdr_q == ECAP_HDR_ALL_ONES) begin
            chk_code_s = ERR_ONES;
        end else if ((hdr_q == 32'h0000_0000) && (cur_off_q == START_OFFSET)) begin
            chk_end_s = 1'b1;
        end else begin
            chk_hop_s = 1'b1;
`ifdef PCIE_ECAP_EARLY_EXIT_EN
            if (all_found_s) begin
                chk_end_s = 1'b1;
            end else
`endif
            if (hdr_q.next == 12'h000) begin
                chk_end_s = 1'b1;
            end else if (ptr_is_bad(hdr_q.next)) begin
                chk_code_s = ERR_PTR;
            end else if (hop_inc_s == 6'(MAX_HOPS)) begin
                chk_code_s = ERR_LOOP;
            end else begin
                chk_end_s = 1'b0;
            end
        end
    end

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_off_q   <= 12'h000;
            hdr_q       <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            hop_q       <= 6'd0;
            err_code_q  <= ERR_NONE;
            req_valid_q <= 1'b0;
            addr_q      <= 10'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_off_q   <= cur_off_d;
            hdr_q       <= hdr_d;
            rsp_err_q   <= rsp_err_d;
            hop_q       <= hop_d;
            err_code_q  <= err_code_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (err_code_d != ERR_NONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_REQ : ST_IDLE;
            ST_REQ:   state_d = rd.rd_req_ready ? ST_WAIT : ST_REQ;
            ST_WAIT:  state_d = rd.rd_rsp_valid ? ST_CHECK : ST_WAIT;
            ST_CHECK: state_d = chk_end_s ? ST_DONE : ST_REQ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values and slot control strobes per state.
    always_comb begin
        cur_off_d   = cur_off_q;
        hdr_d       = hdr_q;
        rsp_err_d   = rsp_err_q;
        hop_d       = hop_q;
        err_code_d  = err_code_q;
        req_valid_d = 1'b0;
        addr_d      = addr_q;
        clear_s     = 1'b0;
        match_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear_s     = 1'b1;
                    cur_off_d   = START_OFFSET;
                    hop_d       = 6'd0;
                    err_code_d  = ERR_NONE;
                    req_valid_d = 1'b1;
                    addr_d      = START_DW;
                end else begin
                    req_valid_d = 1'b0;
                end
            end
            ST_REQ: begin
                req_valid_d = !rd.rd_req_ready;
            end
            ST_WAIT: begin
                if (rd.rd_rsp_valid) begin
                    hdr_d     = ecap_hdr_t'(rd.rd_rsp_data);
                    rsp_err_d = rd.rd_rsp_err;
                end else begin
                    hdr_d     = hdr_q;
                end
            end
            ST_CHECK: begin
                err_code_d = chk_code_s;
                if (chk_hop_s) begin
                    hop_d   = hop_inc_s;
                    match_s = 1'b1;
                end else begin
                    hop_d   = hop_q;
                end
                if (!chk_end_s) begin
                    cur_off_d   = hdr_q.next;
                    req_valid_d = 1'b1;
                    addr_d      = hdr_q.next[11:2];
                end else begin
                    req_valid_d = 1'b0;
                end
            end
            default: begin
                req_valid_d = 1'b0;
            end
        endcase
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign rd.rd_req_valid = req_valid_q;
    assign rd.rd_req_addr  = addr_q;
    assign found           = found_s;
    assign err             = err_q;
    assign err_code        = err_code_q;
    assign hop_count       = hop_q;
endmodule

// File: tb/tb_pcie_ext_cap_walker.sv
// Self-checking bench for pcie_ext_cap_walker: directed table, corner sequences, random chains.
module tb_pcie_ext_cap_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] target_id = 64'h0;
    logic        busy, done, err;
    logic [3:0]  found;
    logic [47:0] found_offset;
    logic [15:0] found_version;
    logic [2:0]  err_code;
    logic [5:0]  hop_count;

    int checks = 0;
    int errors = 0;

    pcie_ext_cap_walker_if ifc ();

    pcie_ext_cap_walker #(.NUM_TARGETS(4), .MAX_HOPS(48), .START_OFFSET(12'h100)) dut (
        .clk(clk), .rst(rst), .start(start), .target_id(target_id),
        .busy(busy), .done(done), .rd(ifc),
        .found(found), .found_offset(found_offset), .found_version(found_version),
        .err(err), .err_code(err_code), .hop_count(hop_count)
    );

    always #5 clk = ~clk;

    // Config space image and responder controls.
    logic [31:0] mem [0:1023];
    int err_dw  = -1;
    int rsp_lat = 1;
    int tot_reads = 0;
    int tot_done  = 0;

    // Responder: accepts at an edge, answers rsp_lat cycles later; counts reads and done pulses.
    always @(posedge clk) begin : responder
        logic       acc;
        logic [9:0] a;
        static int         pend_cnt = 0;
        static logic [9:0] pend_addr = 10'd0;
        acc = (ifc.rd_req_valid === 1'b1) && (ifc.rd_req_ready === 1'b1);
        a   = ifc.rd_req_addr;
        if (done === 1'b1) tot_done++;
        #1;
        ifc.rd_rsp_valid = 1'b0;
        ifc.rd_rsp_err   = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                ifc.rd_rsp_valid = 1'b1;
                ifc.rd_rsp_data  = mem[pend_addr];
                ifc.rd_rsp_err   = (int'(pend_addr) == err_dw);
            end
        end
        if (acc) begin
            tot_reads++;
            if (rsp_lat <= 1) begin
                ifc.rd_rsp_valid = 1'b1;
                ifc.rd_rsp_data  = mem[a];
                ifc.rd_rsp_err   = (int'(a) == err_dw);
            end else begin
                pend_cnt  = rsp_lat - 1;
                pend_addr = a;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [11:0] nx, input logic [3:0] v, input logic [15:0] id);
        return {nx, v, id};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        err_dw = -1;
    endtask

    // Reference model: follows the list in the memory image with plain arithmetic.
    typedef struct {
        logic [3:0]  found;
        logic [47:0] off;
        logic [15:0] ver;
        logic [2:0]  code;
        int          hops;
        int          reads;
    } res_t;

    function automatic res_t model(input logic [63:0] tg);
        res_t        r;
        int          off;
        int          nxt;
        logic [31:0] d;
        logic [15:0] id;
        logic        all_hit;
        r.found = 4'h0; r.off = 48'h0; r.ver = 16'h0; r.code = 3'd0; r.hops = 0; r.reads = 0;
        off = 'h100;
        for (int step = 0; step < 200; step++) begin
            r.reads++;
            d = mem[off / 4];
            if (off / 4 == err_dw) begin r.code = 3'd1; break; end
            if (d == 32'hFFFF_FFFF) begin r.code = 3'd4; break; end
            if (d == 32'h0 && off == 'h100) break;
            r.hops++;
            all_hit = 1'b1;
            for (int i = 0; i < 4; i++) begin
                id = tg[16*i +: 16];
                if (id != 16'h0 && !r.found[i] && id == d[15:0]) begin
                    r.found[i] = 1'b1;
                    r.off[12*i +: 12] = 12'(off);
                    r.ver[4*i +: 4] = d[19:16];
                end
                if (id != 16'h0 && !r.found[i]) all_hit = 1'b0;
            end
`ifdef PCIE_ECAP_EARLY_EXIT_EN
            if (all_hit) break;
`endif
            nxt = int'(d[31:20]);
            if (nxt == 0) break;
            if (nxt < 'h100 || nxt % 4 != 0) begin r.code = 3'd2; break; end
            if (r.hops == 48) begin r.code = 3'd3; break; end
            off = nxt;
        end
        return r;
    endfunction

    // Start a walk and wait (bounded) for done; lat = edges from start sample to the edge sampling done.
    task automatic run_walk(input logic [63:0] tg, output int lat, output int reads, output int dones);
        int k;
        int r0, d0;
        @(negedge clk);
        r0 = tot_reads; d0 = tot_done;
        target_id = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0; target_id = 64'h0;
        chk("busy_after_start", busy, 1);
        k = 0;
        while (done !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        chk("done_seen", done, 1);
        lat = k + 1;
        @(negedge clk); @(negedge clk);
        chk("done_dropped", done, 0);
        chk("busy_idle", busy, 0);
        reads = tot_reads - r0;
        dones = tot_done - d0;
    endtask

    task automatic walk_and_check(input string nm, input logic [63:0] tg);
        res_t e;
        int lat, rds, dns;
        e = model(tg);
        run_walk(tg, lat, rds, dns);
        chk({nm, ".found"}, found, e.found);
        chk({nm, ".offset"}, found_offset, e.off);
        chk({nm, ".version"}, found_version, e.ver);
        chk({nm, ".err_code"}, err_code, e.code);
        chk({nm, ".err"}, err, e.code != 3'd0);
        chk({nm, ".hop_count"}, hop_count, e.hops);
        chk({nm, ".reads"}, rds, e.reads);
        chk({nm, ".done_pulses"}, dns, 1);
    endtask

    typedef struct {
        string       nm;
        int          kind;
        logic [63:0] tg;
        logic [3:0]  ef;
        logic [2:0]  ec;
        int          eh;
        logic [11:0] eoff0;
        logic [3:0]  ever0;
        int          erd;
    } vec_t;

    task automatic build(input int kind);
        clear_mem();
        case (kind)
            0: begin mem[64] = hdr(12'h148, 4'h1, 16'h0001); mem[82] = hdr(12'h000, 4'h2, 16'h000B); end
            2: begin mem[64] = hdr(12'h200, 4'h1, 16'h0001); mem[128] = hdr(12'h100, 4'h1, 16'h0002); end
            3: mem[64] = hdr(12'h0F0, 4'h1, 16'h0001);
            4: mem[64] = hdr(12'h152, 4'h1, 16'h0001);
            5: mem[64] = 32'hFFFF_FFFF;
            6: begin mem[64] = hdr(12'h180, 4'h0, 16'h0000); mem[96] = hdr(12'h000, 4'h3, 16'h0010); end
            7: begin mem[64] = hdr(12'h104, 4'h1, 16'h0007); mem[65] = hdr(12'h000, 4'h2, 16'h0007); end
            default: ;
        endcase
    endtask

    initial begin
        vec_t tbl[8];
        int   lat, rds, dns, n, mode, j;
        int   offs[6];
        logic [63:0] tg;
        logic [11:0] nx;

        tbl[0] = '{"two_hdr",  0, 64'h0000_0000_0001_000B, 4'b0011, 3'd0, 2,  12'h148, 4'h2, 2};
        tbl[1] = '{"empty",    1, 64'h0000_0000_0000_0001, 4'b0000, 3'd0, 0,  12'h000, 4'h0, 1};
        tbl[2] = '{"loop",     2, 64'h0000_0000_0000_0005, 4'b0000, 3'd3, 48, 12'h000, 4'h0, 48};
        tbl[3] = '{"ptr_low",  3, 64'h0000_0000_0000_0009, 4'b0000, 3'd2, 1,  12'h000, 4'h0, 1};
        tbl[4] = '{"ptr_mis",  4, 64'h0000_0000_0000_0009, 4'b0000, 3'd2, 1,  12'h000, 4'h0, 1};
        tbl[5] = '{"ones",     5, 64'h0000_0000_0000_0001, 4'b0000, 3'd4, 0,  12'h000, 4'h0, 1};
        tbl[6] = '{"null_cap", 6, 64'h0000_0000_0000_0010, 4'b0001, 3'd0, 2,  12'h180, 4'h3, 2};
        tbl[7] = '{"dup",      7, 64'h0000_0099_0007_0007, 4'b0011, 3'd0, 2,  12'h100, 4'h1, 2};

        ifc.rd_req_ready = 1'b1;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.req_valid", ifc.rd_req_valid, 0);
        chk("rst.req_addr", ifc.rd_req_addr, 0);
        chk("rst.found", found, 0);
        chk("rst.offset", found_offset, 0);
        chk("rst.version", found_version, 0);
        chk("rst.err", err, 0);
        chk("rst.err_code", err_code, 0);
        chk("rst.hop_count", hop_count, 0);
        rst = 1'b0;

        // Directed table: fixed expectations plus model cross-check.
        for (int v = 0; v < 8; v++) begin
            build(tbl[v].kind);
            walk_and_check(tbl[v].nm, tbl[v].tg);
            chk({tbl[v].nm, ".tbl_found"}, found, tbl[v].ef);
            chk({tbl[v].nm, ".tbl_code"}, err_code, tbl[v].ec);
            chk({tbl[v].nm, ".tbl_hops"}, hop_count, tbl[v].eh);
            chk({tbl[v].nm, ".tbl_off0"}, found_offset[11:0], tbl[v].eoff0);
            chk({tbl[v].nm, ".tbl_ver0"}, found_version[3:0], tbl[v].ever0);
        end

        // Latency: single header 4 edges, each extra hop 3 more.
        clear_mem();
        mem[64] = hdr(12'h000, 4'h1, 16'h0001);
        run_walk(64'h1, lat, rds, dns);
        chk("lat.single", lat, 4);
        build(0);
        run_walk(64'h1, lat, rds, dns);
        chk("lat.two_hdr", lat, 7);

        // Request stall then response error on second hop.
        clear_mem();
        mem[64] = hdr(12'h140, 4'h1, 16'h0001);
        mem[80] = hdr(12'h000, 4'h1, 16'h0002);
        err_dw = 80;
        ifc.rd_req_ready = 1'b0;
        @(negedge clk);
        target_id = 64'h0000_0000_0002_0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall.valid", ifc.rd_req_valid, 1);
            chk("stall.addr", ifc.rd_req_addr, 10'h040);
            @(negedge clk);
        end
        ifc.rd_req_ready = 1'b1;
        j = 0;
        while (done !== 1'b1 && j < 100) begin @(negedge clk); j++; end
        chk("stall.done", done, 1);
        chk("stall.err_code", err_code, 1);
        chk("stall.err", err, 1);
        chk("stall.hops", hop_count, 1);
        chk("stall.found", found, 4'b0001);
        err_dw = -1;

        // Reset during WAIT with the response landing after reset.
        build(0);
        rsp_lat = 2;
        @(negedge clk);
        dns = tot_done;
        target_id = 64'h0000_0000_0001_000B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw.req_valid", ifc.rd_req_valid, 0);
        chk("rstw.busy", busy, 0);
        repeat (4) @(negedge clk);
        chk("rstw.busy_later", busy, 0);
        chk("rstw.found", found, 0);
        chk("rstw.no_done", tot_done - dns, 0);
        rsp_lat = 1;

        // Three-header chain with the sole target at the first header.
        clear_mem();
        mem[64] = hdr(12'h104, 4'h1, 16'h0021);
        mem[65] = hdr(12'h108, 4'h1, 16'h0002);
        mem[66] = hdr(12'h000, 4'h1, 16'h0003);
        run_walk(64'h21, lat, rds, dns);
`ifdef PCIE_ECAP_EARLY_EXIT_EN
        chk("early.hops", hop_count, 1);
        chk("early.reads", rds, 1);
`else
        chk("early.hops", hop_count, 3);
        chk("early.reads", rds, 3);
`endif
        chk("early.found", found, 4'b0001);

        // Random chains with occasional loops, bad pointers, read errors and all-ones headers.
        for (int it = 0; it < 40; it++) begin
            clear_mem();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) offs[i] = (i == 0) ? 'h100 : 'h100 + 4 * (i * 37 + $urandom_range(0, 29));
            for (int i = 0; i < n; i++) begin
                nx = (i == n - 1) ? 12'h000 : 12'(offs[i + 1]);
                mem[offs[i] / 4] = hdr(nx, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 6)));
            end
            mode = $urandom_range(0, 9);
            j = $urandom_range(0, n - 1);
            case (mode)
                0: mem[offs[n-1] / 4][31:20] = 12'(offs[j]);
                1: mem[offs[n-1] / 4][31:20] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 255))
                                                : 12'('h102 + 4 * $urandom_range(0, 200));
                2: err_dw = offs[j] / 4;
                3: mem[offs[j] / 4] = 32'hFFFF_FFFF;
                default: ;
            endcase
            tg = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
            walk_and_check($sformatf("rnd%0d", it), tg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
